// File: rtl/alu_mult_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mult_sequencer
//
// Multi-cycle 32x32 unsigned multiplier controller. It sits beside the
// single-cycle datapath ALU and computes a 64-bit product by driving the
// shared ALU through one shift-and-add iteration per clock. The datapath
// steers the ALU inputs to this block while busy_out is high.
//
// Optional feature macro: MULT_EARLY_EXIT_EN
//   When defined, a multiplication finishes as soon as no set multiplier bit
//   remains to be consumed. The remaining zero-add iterations collapse into a
//   single right shift. The product is identical to the full-length result.
//   When undefined, every multiplication takes exactly WORD_SIZE RUN cycles.
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   synchronous active-high reset
//   start_in         in   multiply request, sampled in IDLE or DONE only
//   multiplicand_in  in   operand A, captured when start is accepted
//   multiplier_in    in   operand B, captured when start is accepted
//   busy_out         out  high while an iteration sequence is running
//   done_out         out  one-cycle completion pulse
//   product_out      out  {hi, lo} product register, valid from DONE onward
//   alu_control_out  out  ALU op code, constant ADD
//   alu_a_out        out  ALU channel A (combinational)
//   alu_b_out        out  ALU channel B (combinational)
//   alu_result_in    in   ALU sum of alu_a_out + alu_b_out, same cycle
// -----------------------------------------------------------------------------
module alu_mult_sequencer #(
    parameter int WORD_SIZE = 32,
    parameter int CNT_W     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_in,
    input  logic [WORD_SIZE-1:0]     multiplicand_in,
    input  logic [WORD_SIZE-1:0]     multiplier_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic [2*WORD_SIZE-1:0]   product_out,
    output logic [3:0]               alu_control_out,
    output logic [WORD_SIZE-1:0]     alu_a_out,
    output logic [WORD_SIZE-1:0]     alu_b_out,
    input  logic [WORD_SIZE-1:0]     alu_result_in
);

    // ALU operation code for addition, matching the CPU constant library.
    localparam logic [3:0] ALU_ADD = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // The ALU has no carry-out port, so the carry of a + b is rebuilt from
    // the operand MSBs and the sum MSB: a carry leaves the top bit when both
    // MSBs are set, or when exactly one is set and the sum MSB came out 0.
    function automatic logic add_carry(input logic a_msb,
                                       input logic b_msb,
                                       input logic r_msb);
        return (a_msb & b_msb) | ((a_msb | b_msb) & ~r_msb);
    endfunction

    state_t                 state_q;
    logic [WORD_SIZE-1:0]   hi_q;
    logic [WORD_SIZE-1:0]   lo_q;
    logic [WORD_SIZE-1:0]   mcand_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   accept_d;
    logic                   carry_d;
    logic                   last_iter_d;
    logic                   run_exit_d;
    logic [2*WORD_SIZE-1:0] step_prod_d;
    logic [2*WORD_SIZE-1:0] prod_next_d;

    // ALU operand steering: the accumulator and the conditionally selected
    // multiplicand go to the ALU only while iterating.
    always_comb begin
        alu_a_out = '0;
        alu_b_out = '0;
        if (state_q == ST_RUN) begin
            alu_a_out = hi_q;
            if (lo_q[0]) begin
                alu_b_out = mcand_q;
            end else begin
                alu_b_out = '0;
            end
        end else begin
            alu_a_out = '0;
            alu_b_out = '0;
        end
    end

    // One shift-and-add step: the 33-bit sum lands in hi, the product shifts
    // right by one, and the consumed multiplier bit drops off the bottom of lo.
    always_comb begin
        accept_d    = start_in & ((state_q == ST_IDLE) | (state_q == ST_DONE));
        carry_d     = add_carry(alu_a_out[WORD_SIZE-1],
                                alu_b_out[WORD_SIZE-1],
                                alu_result_in[WORD_SIZE-1]);
        step_prod_d = {carry_d, alu_result_in, lo_q[WORD_SIZE-1:1]};
        last_iter_d = (cnt_q == CNT_W'(WORD_SIZE - 1));
    end

`ifdef MULT_EARLY_EXIT_EN
    logic [CNT_W-1:0]     rem_bits_d;
    logic [WORD_SIZE-1:0] pending_mask_d;
    logic                 no_pending_d;

    // Early exit: lo[rem:1] holds the multiplier bits not yet consumed. When
    // they are all zero, every remaining iteration would add zero and shift,
    // so those rem shifts are applied at once and the run ends this cycle.
    // On the last iteration rem is 0, the mask is empty and no shift occurs.
    always_comb begin
        rem_bits_d     = CNT_W'(WORD_SIZE - 1) - cnt_q;
        pending_mask_d = (WORD_SIZE'(1) << rem_bits_d) - WORD_SIZE'(1);
        no_pending_d   = (((lo_q >> 1) & pending_mask_d) == '0);
        if (no_pending_d) begin
            prod_next_d = step_prod_d >> rem_bits_d;
        end else begin
            prod_next_d = step_prod_d;
        end
        run_exit_d = last_iter_d | no_pending_d;
    end
`else
    // Fixed-length run: always WORD_SIZE iterations.
    always_comb begin
        prod_next_d = step_prod_d;
        run_exit_d  = last_iter_d;
    end
`endif

    // Control FSM plus product/operand registers and registered handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (accept_d) begin
            // Accepted in IDLE or DONE: operands are captured only here.
            state_q <= ST_RUN;
            mcand_q <= multiplicand_in;
            hi_q    <= '0;
            lo_q    <= multiplier_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                ST_RUN: begin
                    {hi_q, lo_q} <= prod_next_d;
                    cnt_q        <= cnt_q + CNT_W'(1);
                    if (run_exit_d) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign product_out     = {hi_q, lo_q};
    assign alu_control_out = ALU_ADD;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
module tb_alu_mult_sequencer;

    logic        clk;
    logic        rst;
    logic        start_in;
    logic [31:0] multiplicand_in;
    logic [31:0] multiplier_in;
    logic        busy_out;
    logic        done_out;
    logic [63:0] product_out;
    logic [3:0]  alu_control_out;
    logic [31:0] alu_a_out;
    logic [31:0] alu_b_out;
    logic [31:0] alu_result_in;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    alu_mult_sequencer #(.WORD_SIZE(32), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_in        (start_in),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .product_out     (product_out),
        .alu_control_out (alu_control_out),
        .alu_a_out       (alu_a_out),
        .alu_b_out       (alu_b_out),
        .alu_result_in   (alu_result_in)
    );

    // Shared datapath ALU performing ADD.
    assign alu_result_in = alu_a_out + alu_b_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected number of RUN cycles for a given multiplier.
    function automatic int exp_latency(input logic [31:0] b);
        int h = 0;
        for (int i = 0; i < 32; i++) if (b[i]) h = i;
        return EARLY ? h + 1 : 32;
    endfunction

    // Drive a start at a negedge; return at the negedge after acceptance (k=0).
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start_in        = 1'b1;
        multiplicand_in = a;
        multiplier_in   = b;
        @(posedge clk);
        @(negedge clk);
        start_in = 1'b0;
    endtask

    // Wait for done starting at run cycle k0, checking ALU traffic on the way.
    task automatic finish_check(input logic [31:0] a, input logic [31:0] b,
                                input int k0, input string name);
        logic [63:0] exp_p;
        logic [63:0] mask;
        logic [31:0] ea;
        logic [31:0] eb;
        int lat;
        int k;
        int busy_cnt;
        int op_err;
        int ctl_err;
        exp_p = 64'(a) * 64'(b);
        lat = exp_latency(b);
        k = k0; busy_cnt = 0; op_err = 0; ctl_err = 0;
        while (done_out !== 1'b1 && k < 100) begin
            if (busy_out === 1'b1) busy_cnt++;
            if (k < 32) begin
                // After k iterations hi holds (a * b[k-1:0]) >> k.
                mask = (64'd1 << k) - 64'd1;
                ea   = 32'((64'(a) * (64'(b) & mask)) >> k);
                eb   = b[k] ? a : 32'd0;
                if (alu_a_out !== ea || alu_b_out !== eb) op_err++;
            end
            if (alu_control_out !== 4'b0010) ctl_err++;
            multiplicand_in = $urandom;
            multiplier_in   = $urandom;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (done_out !== 1'b1 || k != lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles (done=%b), want %0d", name, k, done_out, lat);
        end
        n_checks++;
        if (busy_cnt != lat - k0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy: got %0d busy cycles (busy now %b), want %0d", name, busy_cnt, busy_out, lat - k0);
        end
        n_checks++;
        if (product_out !== exp_p) begin
            n_fail++;
            $display("FAIL %s product: got %h, want %h", name, product_out, exp_p);
        end
        n_checks++;
        if (op_err != 0) begin
            n_fail++;
            $display("FAIL %s alu_operands: got %0d bad cycles, want 0", name, op_err);
        end
        n_checks++;
        if (ctl_err != 0 || alu_control_out !== 4'b0010) begin
            n_fail++;
            $display("FAIL %s alu_control: got %0d bad cycles (now %b), want 0010", name, ctl_err, alu_control_out);
        end
    endtask

    // Full single multiply followed by a check of the pulse and idle outputs.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input string name);
        launch(a, b);
        finish_check(a, b, 0, name);
        @(negedge clk);
        n_checks++;
        if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse: got done=%b busy=%b, want 0 0", name, done_out, busy_out);
        end
        n_checks++;
        if (alu_a_out !== 32'd0 || alu_b_out !== 32'd0 || product_out !== 64'(a) * 64'(b)) begin
            n_fail++;
            $display("FAIL %s idle_hold: got a=%h b=%h p=%h, want 0 0 %h",
                     name, alu_a_out, alu_b_out, product_out, 64'(a) * 64'(b));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_in = 1'b0; multiplicand_in = 32'd0; multiplier_in = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || product_out !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b p=%h, want 0 0 0", busy_out, done_out, product_out);
        end
        n_checks++;
        if (alu_a_out !== 32'd0 || alu_b_out !== 32'd0 || alu_control_out !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_alu: got a=%h b=%h ctl=%b, want 0 0 0010", alu_a_out, alu_b_out, alu_control_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_mult(32'd3, 32'd5, "basic_3x5");
    endtask

    task automatic test_carry();
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "carry_ffxff");
    endtask

    task automatic test_zero();
        run_mult(32'd0, 32'h1234_5678, "zero_a");
        run_mult(32'h1234_5678, 32'd0, "zero_b");
    endtask

    task automatic test_back_to_back();
        int pulse_k;
        pulse_k = (exp_latency(32'd9) > 11) ? 10 : 1;
        launch(32'd7, 32'd9);
        repeat (pulse_k) @(negedge clk);
        start_in = 1'b1; multiplicand_in = 32'd2; multiplier_in = 32'd2;
        @(negedge clk);
        start_in = 1'b0;
        finish_check(32'd7, 32'd9, pulse_k + 1, "busy_ignore_7x9");
        // Start held during the DONE cycle is accepted directly.
        launch(32'd6, 32'd7);
        finish_check(32'd6, 32'd7, 0, "b2b_6x7");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        launch(32'd123, 32'h8000_0001);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || product_out !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b p=%h, want 0 0 0", busy_out, done_out, product_out);
        end
        run_mult(32'd4, 32'd4, "after_reset_4x4");
    endtask

    task automatic test_early_exit();
        run_mult(32'd7, 32'd1, "early_7x1");
        run_mult(32'h0000_FFFF, 32'h8000_0000, "early_ffff_x_msb");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run_mult(a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_early_exit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
